// File: rtl/sensor_sweep_if.sv
// Bundles the lab-controller handshake and the detector-under-test signals of sensor_sweep.
// The sweeper takes the slave side; the lab/test environment takes the master side.
interface sensor_sweep_if;
   logic       start;
   logic       error;
   logic [3:0] sensors;
   logic       busy;
   logic       done;
   logic       fail;
   logic [4:0] mismatch_count;
   logic [3:0] first_fail;

   modport master (
      output start, error,
      input  sensors, busy, done, fail, mismatch_count, first_fail
   );

   modport slave (
      input  start, error,
      output sensors, busy, done, fail, mismatch_count, first_fail
   );
endinterface

// File: rtl/sensor_sweep.sv
// Self-test initiator: steps all 16 sensor patterns into the error detector, samples its
// response after a settle time and compares against the golden detector equation.
//
// state  | meaning
// IDLE   | sensors=0, waiting for start; results from the last sweep held
// DRIVE  | current pattern on sensors, settle counter running
// SAMPLE | one cycle; error compared with the golden value at the closing edge
// DONE   | one-cycle done pulse, sensors back to 0
module sensor_sweep #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic          clk,
   input  logic          n_rst,
   sensor_sweep_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     r_state;
   logic [3:0] r_pattern;
   logic [3:0] r_settle;
   logic       r_busy;
   logic       r_done;
   logic       r_fail;
   logic [4:0] r_mismatch;
   logic [3:0] r_first_fail;

   state_t     w_state;
   logic [3:0] w_pattern;
   logic [3:0] w_settle;
   logic       w_busy;
   logic       w_done;
   logic       w_fail;
   logic [4:0] w_mismatch;
   logic [3:0] w_first_fail;
   logic       w_golden;
   logic       w_miss;

   assign w_golden = r_pattern[0] | (r_pattern[1] & (r_pattern[2] | r_pattern[3]));
   assign w_miss   = bus.error ^ w_golden;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state      <= IDLE;
         r_pattern    <= 4'd0;
         r_settle     <= 4'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_fail       <= 1'b0;
         r_mismatch   <= 5'd0;
         r_first_fail <= 4'd0;
      end else begin
         r_state      <= w_state;
         r_pattern    <= w_pattern;
         r_settle     <= w_settle;
         r_busy       <= w_busy;
         r_done       <= w_done;
         r_fail       <= w_fail;
         r_mismatch   <= w_mismatch;
         r_first_fail <= w_first_fail;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_pattern    = r_pattern;
      w_settle     = r_settle;
      w_fail       = r_fail;
      w_mismatch   = r_mismatch;
      w_first_fail = r_first_fail;

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state      = DRIVE;
               w_pattern    = 4'd0;
               w_settle     = 4'd0;
               w_fail       = 1'b0;
               w_mismatch   = 5'd0;
               w_first_fail = 4'd0;
            end
         end
         DRIVE: begin
            w_settle = r_settle + 4'd1;
            if (r_settle == SETTLE_LAST) begin
               w_state = SAMPLE;
            end
         end
         SAMPLE: begin
            if (w_miss) begin
               if (r_mismatch != 5'd16) begin
                  w_mismatch = r_mismatch + 5'd1;
               end
               if (!r_fail) begin
                  w_first_fail = r_pattern;
               end
               w_fail = 1'b1;
            end
            // Pattern is zeroed on the way into DONE so sensors returns to 0 there.
            if (r_pattern == 4'd15) begin
               w_state   = DONE;
               w_pattern = 4'd0;
            end else begin
               w_state   = DRIVE;
               w_pattern = r_pattern + 4'd1;
               w_settle  = 4'd0;
            end
         end
         DONE: begin
            w_state = IDLE;
         end
         default: begin
            w_state = IDLE;
         end
      endcase

      w_busy = (w_state == DRIVE) || (w_state == SAMPLE);
      w_done = (w_state == DONE);
   end

   assign bus.sensors        = r_pattern;
   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
   assign bus.fail           = r_fail;
   assign bus.mismatch_count = r_mismatch;
   assign bus.first_fail     = r_first_fail;

endmodule
